// File: rtl/lv_pwm_intb_encode.sv
// Single-wire interrupt encoder: one edge signals "assert", three edges signal
// "deassert", and a quiet gap follows every message so the receiver can frame it.
module lv_pwm_intb_encode #(
   parameter int SEG_CYC = 6,
   parameter int GAP_CYC = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_intb_n,
   output logic o_pwm_intb_n,
   output logic o_busy,
   output logic o_msg_done
);

   localparam int MAX_CYC = (SEG_CYC > GAP_CYC) ? SEG_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] SEG_LOAD = CNT_W'(SEG_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DA_HI1 = 2'd1,
      ST_DA_LO  = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             pwm_r, pwm_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;

   // Next-state, counter and output decode; the line level only moves on state entry.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pwm_s   = pwm_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (i_intb_n != pwm_r) begin
               if (i_intb_n == 1'b0) begin
                  state_s = ST_GAP;
                  cnt_s   = GAP_LOAD;
                  pwm_s   = 1'b0;
               end else begin
                  state_s = ST_DA_HI1;
                  cnt_s   = SEG_LOAD;
                  pwm_s   = 1'b1;
               end
            end else begin
               cnt_s = CNT_ZERO;
            end
         end
         ST_DA_HI1: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_DA_LO;
               cnt_s   = SEG_LOAD;
               pwm_s   = 1'b0;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_DA_LO: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_GAP;
               cnt_s   = GAP_LOAD;
               pwm_s   = 1'b1;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_IDLE;
               done_s  = 1'b1;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            pwm_s   = 1'b1;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State, counter and registered outputs; reset aborts any message without a done pulse.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         pwm_r   <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         pwm_r   <= pwm_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign o_pwm_intb_n = pwm_r;
   assign o_busy       = busy_r;
   assign o_msg_done   = done_r;

endmodule
